// File: rtl/cam_pixel_source_if.sv
// cam_pixel_source_if: camera-style video bus (pclk, v_sync, h_ref, data_out).
// The master side is the pixel source and the slave side is a receiver such as vga_driver.
interface cam_pixel_source_if;
    logic       pclk;
    logic       v_sync;
    logic       h_ref;
    logic [7:0] data_out;

    modport master (output pclk, output v_sync, output h_ref, output data_out);
    modport slave  (input  pclk, input  v_sync, input  h_ref, input  data_out);
endinterface

// File: rtl/cam_pixel_source.sv
// cam_pixel_source: on-chip OV7670-style test pixel transmitter in the clk_50 domain.
// pclk is clk_50/2. All video outputs change on pclk falling, so they are stable when pclk rises.
// Optional macro CAM_PIXEL_SOURCE_RGB565_EN sends two bytes (RGB565, high byte first) per pixel.
module cam_pixel_source #(
    parameter int H_TOTAL      = 785,
    parameter int H_ACT_START  = 144,
    parameter int H_ACT_END    = 784,
    parameter int V_TOTAL      = 511,
    parameter int VSYNC_LINES  = 3,
    parameter int V_ACT_START  = 20,
    parameter int V_ACT_END    = 500,
    parameter int BOX_MARGIN_H = 80,
    parameter int BOX_MARGIN_V = 60
) (
    input  logic                   clk_50,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             pattern,
    cam_pixel_source_if.master     video,
    output logic                   frame_done,
    output logic [15:0]            frame_count,
    output logic                   busy
);

`ifdef CAM_PIXEL_SOURCE_RGB565_EN
    localparam int ACT_W = (H_ACT_END - H_ACT_START) / 2;
`else
    localparam int ACT_W = H_ACT_END - H_ACT_START;
`endif
    localparam int ACT_H = V_ACT_END - V_ACT_START;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_A0    = 10'(H_ACT_START);
    localparam logic [9:0] H_A1    = 10'(H_ACT_END);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_SY    = 9'(VSYNC_LINES);
    localparam logic [8:0] V_A0    = 9'(V_ACT_START);
    localparam logic [8:0] V_A1    = 9'(V_ACT_END);
    localparam logic [9:0] BOX_H0  = 10'(BOX_MARGIN_H);
    localparam logic [9:0] BOX_H1  = 10'(ACT_W - BOX_MARGIN_H);
    localparam logic [8:0] BOX_V0  = 9'(BOX_MARGIN_V);
    localparam logic [8:0] BOX_V1  = 9'(ACT_H - BOX_MARGIN_V);
    localparam logic [9:0] BAR_W   = 10'(ACT_W / 8);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, next_state;
    logic [9:0]  h_count, next_h;
    logic [8:0]  v_count, next_v;
    logic [1:0]  pat_q, pat_sel;
    logic        pclk_q, tick, start_frame, frame_end;
    logic [15:0] fc_next;
    logic        vs_q, href_q;
    logic [7:0]  data_q;
    logic [9:0]  px_raw, px;
    logic [8:0]  py;
    logic        in_box;
    logic [2:0]  bar;
    logic [7:0]  g, pix_byte;
    logic        vs_d, href_d;
    logic [7:0]  data_d;
`ifdef CAM_PIXEL_SOURCE_RGB565_EN
    logic [15:0] rgb;
`endif

    // tick is the clk_50 cycle in which pclk is high, so everything below moves on pclk falling
    assign tick = pclk_q;

    assign video.pclk     = pclk_q;
    assign video.v_sync   = vs_q;
    assign video.h_ref    = href_q;
    assign video.data_out = data_q;

    // Free-running pixel clock at half the system clock
    always_ff @(posedge clk_50) begin
        if (reset) pclk_q <= 1'b0;
        else       pclk_q <= ~pclk_q;
    end

    // FSM state register, advanced only on ticks
    always_ff @(posedge clk_50) begin
        if (reset)     state <= IDLE;
        else if (tick) state <= next_state;
    end

    // Next state and next raster position; a frame boundary restarts at (0,0) with no gap
    always_comb begin
        next_state  = state;
        next_h      = h_count;
        next_v      = v_count;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                next_h = 10'd0;
                next_v = 9'd0;
                if (enable) begin
                    next_state  = RUN;
                    start_frame = 1'b1;
                end
            end
            RUN: begin
                if (h_count == H_LAST) begin
                    next_h = 10'd0;
                    if (v_count == V_LAST) begin
                        next_v    = 9'd0;
                        frame_end = 1'b1;
                        if (enable) start_frame = 1'b1;
                        else        next_state  = IDLE;
                    end else begin
                        next_v = v_count + 9'd1;
                    end
                end else begin
                    next_h = h_count + 10'd1;
                end
            end
            default: next_state = IDLE;
        endcase
        fc_next = frame_count + 16'(frame_end);
        pat_sel = start_frame ? pattern : pat_q;
    end

    // Decode the position about to be emitted into sync, line-valid and pixel byte
    always_comb begin
        px_raw = next_h - H_A0;
`ifdef CAM_PIXEL_SOURCE_RGB565_EN
        px     = {1'b0, px_raw[9:1]};
`else
        px     = px_raw;
`endif
        py     = next_v - V_A0;
        in_box = (px >= BOX_H0) && (px < BOX_H1) && (py >= BOX_V0) && (py < BOX_V1);
        bar    = 3'(px / BAR_W);
        g      = 8'd0;
        case (pat_sel)
            2'd0:    g = in_box ? 8'h00 : 8'hFF;
            2'd1:    g = {bar, bar, bar[2:1]};
            2'd2:    g = px[7:0];
            default: g = fc_next[7:0];
        endcase
`ifdef CAM_PIXEL_SOURCE_RGB565_EN
        rgb      = {g[7:3], g[7:2], g[7:3]};
        pix_byte = px_raw[0] ? rgb[7:0] : rgb[15:8];
`else
        pix_byte = g;
`endif
        vs_d   = (next_state == RUN) && (next_v < V_SY);
        href_d = (next_state == RUN) && !vs_d &&
                 (next_v >= V_A0) && (next_v < V_A1) &&
                 (next_h >= H_A0) && (next_h < H_A1);
        data_d = href_d ? pix_byte : 8'd0;
    end

    // Counters, latched pattern and registered outputs; frame_done lasts exactly the tick edge's cycle
    always_ff @(posedge clk_50) begin
        if (reset) begin
            h_count     <= 10'd0;
            v_count     <= 9'd0;
            pat_q       <= 2'd0;
            vs_q        <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_done <= tick && frame_end;
            if (tick) begin
                h_count     <= next_h;
                v_count     <= next_v;
                frame_count <= fc_next;
                vs_q        <= vs_d;
                href_q      <= href_d;
                data_q      <= data_d;
                busy        <= (next_state == RUN);
                if (start_frame) pat_q <= pattern;
            end
        end
    end

endmodule

// File: doc/cam_pixel_source.md
Name: cam_pixel_source

Overview:
- Synthesizable camera-side pixel transmitter. Drives the same interface the vga_driver receives: pclk, v_sync, h_ref and 8-bit data, with OV7670-style raster timing.
- Provides an on-chip, deterministic test source. It can replace the physical camera for bring-up and for closed-loop vga_driver regression.
- Sits in the clk_50 domain. pclk is generated internally as clk_50/2.

Parameters:
- H_TOTAL, 785, pclk cycles per line (h_count 0..H_TOTAL-1).
- H_ACT_START, 144, first h_count with h_ref high.
- H_ACT_END, 784, first h_count after the active window (exclusive).
- V_TOTAL, 511, lines per frame (v_count 0..V_TOTAL-1).
- VSYNC_LINES, 3, v_sync is high for v_count < VSYNC_LINES.
- V_ACT_START, 20, first active line.
- V_ACT_END, 500, first line after the active window (exclusive).
- BOX_MARGIN_H, 80, horizontal inset of the box pattern, in pixels.
- BOX_MARGIN_V, 60, vertical inset of the box pattern, in lines.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled at frame boundaries.
- pattern  in  2  test pattern select; latched at frame start.
- pclk  out  1  pixel clock, clk_50/2, registered.
- v_sync  out  1  frame sync.
- h_ref  out  1  line-valid.
- data_out  out  8  pixel byte.
- frame_done  out  1  one clk_50 pulse at the end of each frame.
- frame_count  out  16  completed frames; wraps at 0xFFFF->0.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (synchronous; applies on any clk_50 edge, including mid-frame):
  - pclk, v_sync, h_ref, frame_done and busy go to 0.
  - data_out, frame_count, h_count and v_count go to 0.
  - state = IDLE.
- Pixel clock:
  - pclk toggles every clk_50 cycle once out of reset.
  - pclk free-runs in both states.
- Tick:
  - tick = clk_50 cycle in which pclk is currently 1, so pclk falls on that edge.
  - All timing outputs and counters update only on tick. Outputs therefore change on pclk falling and are stable across pclk rising, where the receiver samples.
- State machine:
  - IDLE:
    - Counters held at 0; v_sync = h_ref = 0; data_out = 0; busy = 0.
    - On a tick with enable = 1: latch pattern, go to RUN, and emit position (0,0) on that same tick. busy = 1.
  - RUN:
    - Each tick advances h_count. At H_TOTAL-1 it wraps to 0 and v_count increments.
    - At (H_TOTAL-1, V_TOTAL-1) the frame ends. frame_done pulses for exactly one clk_50 cycle (the tick cycle) and frame_count increments.
    - If enable = 1 at frame end: re-latch pattern, stay in RUN, and emit (0,0) on the next tick with no gap.
    - If enable = 0 at frame end: go to IDLE.
    - Deasserting enable mid-frame has no effect until the frame ends. Frames are never truncated except by reset.
- Output decode (registered from the position being emitted):
  - v_sync = 1 when v_count < VSYNC_LINES.
  - h_ref = 1 when V_ACT_START <= v_count < V_ACT_END and H_ACT_START <= h_count < H_ACT_END. h_ref is never high while v_sync is high.
  - data_out = 0 whenever h_ref = 0.
- Pixel coordinates:
  - px = h_count - H_ACT_START (10 bits); py = v_count - V_ACT_START (9 bits).
  - Defaults give 640x480.
- Patterns (latched value):
  - 0 box: data = 0 when BOX_MARGIN_H <= px < W-BOX_MARGIN_H and BOX_MARGIN_V <= py < 480-BOX_MARGIN_V; otherwise 255. W is the active width in pixels.
  - 1 bars: b = px / (W/8), 3 bits. data = {b, b, b[2:1]}.
  - 2 ramp: data = px[7:0], wrapping every 256 pixels.
  - 3 frame: data = frame_count[7:0] for every active pixel.
- Simultaneous events:
  - reset has priority over everything.
  - frame_done and a new-frame start coincide on the same tick.
  - A pattern change mid-frame is ignored until the next frame start.

Optional Feature:
- Macro: CAM_PIXEL_SOURCE_RGB565_EN.
- Defined:
  - Two bytes per pixel, high byte first; W = (H_ACT_END - H_ACT_START)/2 = 320.
  - px = (h_count - H_ACT_START) >> 1.
  - The 8-bit pattern value g is expanded to RGB565 {g[7:3], g[7:2], g[7:3]}.
  - Even active byte = bits [15:8]; odd active byte = bits [7:0].
- Undefined:
  - One byte per pixel; W = H_ACT_END - H_ACT_START = 640; data_out = g directly.

Test Plan:
- Reset/idle: reset 1 for 4 cycles, then enable = 0 for 100 cycles. Required: pclk toggling; v_sync = h_ref = data_out = busy = 0; frame_count = 0.
- Line/frame timing: enable = 1, pattern = 0. Required:
  - 785 ticks per line; v_sync high for lines 0..2.
  - h_ref high for exactly 640 ticks per line on lines 20..499 only.
  - frame_done pulses once per 785*511 ticks; frame_count = 1 after the first frame.
- Box content: pattern 0. Line 80, px 79/80/559/560 -> 255/0/0/255. Line 79 -> all 255. Line 439 px 80 -> 0. Line 440 px 80 -> 255.
- Enable/pattern at boundary: set pattern from 2 to 1 and drop enable mid-frame. Required: ramp continues to frame end (px 300 -> 44); frame_done fires; IDLE on the next tick; re-enable starts at (0,0) with bars (px 85 -> 0x24).
- Reset mid-frame: assert reset at line 250. Required: next clk_50 edge gives all outputs 0, counters 0, frame_count 0.
- RGB565 (macro defined): pattern 0 on line 80. Required: bytes at px 0 are 0xFF, 0xFF; at px 80 they are 0x00, 0x00; 320 pixels per line; h_ref still high for 640 ticks.
